// File: rtl/sdram_pkg.sv
`default_nettype none
// ============================================================================
// sdram_pkg
// Command encodings, bus widths and arbiter state type for the SDRAM port.
// Revision: 1.0
// ============================================================================
package sdram_pkg;

    localparam int unsigned SDRC_ADDR_W = 21;
    localparam int unsigned SDRC_DATA_W = 32;
    localparam int unsigned SDRC_LEN_W  = 8;

    typedef enum logic [2:0] {
        SDRC_NOP      = 3'b111,
        SDRC_REFRESH  = 3'b001,
        SDRC_ACTIVATE = 3'b011,
        SDRC_WRITE    = 3'b100,
        SDRC_READ     = 3'b101
    } sdrc_cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_OWN0         = 3'd1,
        ST_OWN1         = 3'd2,
        ST_REFRESH      = 3'd3,
        ST_REFRESH_WAIT = 3'd4
    } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/sdram_arbiter_if.sv
`default_nettype none
// ============================================================================
// sdram_arbiter_if
// One burst master's view of the shared SDRAM controller command port.
// Revision: 1.0
// ============================================================================
interface sdram_arbiter_if;
    import sdram_pkg::*;

    logic                   req;
    logic                   grant;
    logic                   cmd_en;
    logic [2:0]             cmd;
    logic [SDRC_ADDR_W-1:0] addr;
    logic [SDRC_DATA_W-1:0] data;
    logic [SDRC_LEN_W-1:0]  data_len;
    logic                   cmd_ack;
    logic [SDRC_DATA_W-1:0] rdata;

    modport master (
        output req, cmd_en, cmd, addr, data, data_len,
        input  grant, cmd_ack, rdata
    );

    modport slave (
        input  req, cmd_en, cmd, addr, data, data_len,
        output grant, cmd_ack, rdata
    );
endinterface
`default_nettype wire

// File: rtl/sdram_refresh_timer.sv
`default_nettype none
// ============================================================================
// sdram_refresh_timer
// Free-running refresh interval counter with sticky pending/overrun flags.
// Revision: 1.0
// ============================================================================
module sdram_refresh_timer #(
    parameter int unsigned REFRESH_INTERVAL_CYCLES = 780
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    output logic pending_o,
    output logic overrun_o
);
    localparam int unsigned CNT_W = (REFRESH_INTERVAL_CYCLES > 1) ?
                                    $clog2(REFRESH_INTERVAL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_INTERVAL_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pending_q, pending_d;
    logic             overrun_q, overrun_d;
    logic             wrap;

    assign wrap = (cnt_q == CNT_LAST);

    // A wrap coinciding with the clear is a fresh request, not an overrun.
    always_comb begin
        cnt_d     = wrap ? '0 : cnt_q + 1'b1;
        pending_d = wrap ? 1'b1 : (pending_q & ~clear_i);
        overrun_d = overrun_q | (wrap & pending_q & ~clear_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    assign pending_o = pending_q;
    assign overrun_o = overrun_q;
endmodule
`default_nettype wire

// File: rtl/sdram_arbiter.sv
`default_nettype none
// ============================================================================
// sdram_arbiter
// Round-robin whole-transaction arbiter for two masters with refresh insertion.
// Revision: 1.0
// ============================================================================
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int unsigned REFRESH_INTERVAL_CYCLES = 780,
    parameter int unsigned REFRESH_WAIT_CYCLES     = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    sdram_arbiter_if.slave         m0,
    sdram_arbiter_if.slave         m1,
    output logic                   I_sdrc_cmd_en,
    output logic [2:0]             I_sdrc_cmd,
    output logic [SDRC_ADDR_W-1:0] I_sdrc_addr,
    output logic [SDRC_DATA_W-1:0] I_sdrc_data,
    output logic [SDRC_LEN_W-1:0]  I_sdrc_data_len,
    input  logic                   O_sdrc_cmd_ack,
    input  logic [SDRC_DATA_W-1:0] O_sdrc_data,
    input  logic                   O_sdrc_init_done,
    output logic                   refresh_overrun
);
    localparam int unsigned WAIT_W = (REFRESH_WAIT_CYCLES > 1) ?
                                     $clog2(REFRESH_WAIT_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = (REFRESH_WAIT_CYCLES > 0) ?
                                              WAIT_W'(REFRESH_WAIT_CYCLES - 1) : '0;

    arb_state_e        state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              refresh_pending;
    logic              refresh_issue;

    sdram_refresh_timer #(
        .REFRESH_INTERVAL_CYCLES(REFRESH_INTERVAL_CYCLES)
    ) u_refresh_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (refresh_issue),
        .pending_o (refresh_pending),
        .overrun_o (refresh_overrun)
    );

    assign refresh_issue = (state_q == ST_IDLE) & O_sdrc_init_done & refresh_pending;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        wait_d       = wait_q;
        case (state_q)
            ST_IDLE: begin
                if (refresh_issue) begin
                    state_d = ST_REFRESH;
                end else if (O_sdrc_init_done) begin
                    // On a tie the master that did not own last goes next.
                    if (m0.req && (!m1.req || last_grant_q)) begin
                        state_d      = ST_OWN0;
                        last_grant_d = 1'b0;
                    end else if (m1.req) begin
                        state_d      = ST_OWN1;
                        last_grant_d = 1'b1;
                    end
                end
            end
            ST_OWN0: if (!m0.req) state_d = ST_IDLE;
            ST_OWN1: if (!m1.req) state_d = ST_IDLE;
            ST_REFRESH: begin
                wait_d  = WAIT_LOAD;
                state_d = ST_REFRESH_WAIT;
            end
            ST_REFRESH_WAIT: begin
                if (wait_q == '0) state_d = ST_IDLE;
                else              wait_d  = wait_q - 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            wait_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            wait_q       <= wait_d;
        end
    end

    always_comb begin
        I_sdrc_cmd_en   = 1'b0;
        I_sdrc_cmd      = SDRC_NOP;
        I_sdrc_addr     = '0;
        I_sdrc_data     = '0;
        I_sdrc_data_len = '0;
        case (state_q)
            ST_OWN0: begin
                I_sdrc_cmd_en   = m0.cmd_en;
                I_sdrc_cmd      = m0.cmd;
                I_sdrc_addr     = m0.addr;
                I_sdrc_data     = m0.data;
                I_sdrc_data_len = m0.data_len;
            end
            ST_OWN1: begin
                I_sdrc_cmd_en   = m1.cmd_en;
                I_sdrc_cmd      = m1.cmd;
                I_sdrc_addr     = m1.addr;
                I_sdrc_data     = m1.data;
                I_sdrc_data_len = m1.data_len;
            end
            ST_IDLE: begin
                if (refresh_issue) begin
                    I_sdrc_cmd_en = 1'b1;
                    I_sdrc_cmd    = SDRC_REFRESH;
                end
            end
            default: ;
        endcase
    end

    assign m0.grant   = (state_q == ST_OWN0);
    assign m1.grant   = (state_q == ST_OWN1);
    assign m0.cmd_ack = O_sdrc_cmd_ack & m0.grant;
    assign m1.cmd_ack = O_sdrc_cmd_ack & m1.grant;
    assign m0.rdata   = O_sdrc_data;
    assign m1.rdata   = O_sdrc_data;
endmodule
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`default_nettype none
// ============================================================================
// tb_sdram_arbiter
// Randomized two-master traffic against a transaction-level arbiter model.
// Revision: 1.0
// ============================================================================
module tb_sdram_arbiter;
    import sdram_pkg::*;

    localparam int INTERVAL = 100;
    localparam int WAITC    = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        I_sdrc_cmd_en;
    logic [2:0]  I_sdrc_cmd;
    logic [20:0] I_sdrc_addr;
    logic [31:0] I_sdrc_data;
    logic [7:0]  I_sdrc_data_len;
    logic        O_sdrc_cmd_ack;
    logic [31:0] O_sdrc_data;
    logic        O_sdrc_init_done;
    logic        refresh_overrun;

    sdram_arbiter_if m0_if ();
    sdram_arbiter_if m1_if ();

    always #5 clk = ~clk;

    sdram_arbiter #(
        .REFRESH_INTERVAL_CYCLES(INTERVAL),
        .REFRESH_WAIT_CYCLES    (WAITC)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .m0               (m0_if),
        .m1               (m1_if),
        .I_sdrc_cmd_en    (I_sdrc_cmd_en),
        .I_sdrc_cmd       (I_sdrc_cmd),
        .I_sdrc_addr      (I_sdrc_addr),
        .I_sdrc_data      (I_sdrc_data),
        .I_sdrc_data_len  (I_sdrc_data_len),
        .O_sdrc_cmd_ack   (O_sdrc_cmd_ack),
        .O_sdrc_data      (O_sdrc_data),
        .O_sdrc_init_done (O_sdrc_init_done),
        .refresh_overrun  (refresh_overrun)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: owner -1 = free, 0/1 = master, 2 = refresh in progress.
    int m_owner, m_blk, m_last, m_t;
    bit m_pend, m_ovr;
    bit req[2];
    int hold[2];

    task automatic model_reset();
        m_owner = -1; m_blk = 0; m_last = 1; m_t = 0; m_pend = 0; m_ovr = 0;
    endtask

    task automatic model_step();
        bit issue, wrap;
        issue = (m_owner == -1) && O_sdrc_init_done && m_pend;
        wrap  = (m_t % INTERVAL) == INTERVAL - 1;
        if (m_owner == -1) begin
            if (issue) begin
                m_owner = 2; m_blk = 1 + WAITC;
            end else if (O_sdrc_init_done && (req[0] || req[1])) begin
                if (req[0] && req[1]) m_owner = (m_last == 0) ? 1 : 0;
                else                  m_owner = req[0] ? 0 : 1;
                m_last = m_owner;
            end
        end else if (m_owner == 2) begin
            m_blk--;
            if (m_blk == 0) m_owner = -1;
        end else if (!req[m_owner]) begin
            m_owner = -1;
        end
        if (wrap) begin
            if (m_pend && !issue) m_ovr = 1;
            m_pend = 1;
        end else if (issue) begin
            m_pend = 0;
        end
        m_t++;
    endtask

    task automatic check_outputs();
        logic        e_en;
        logic [2:0]  e_cmd;
        logic [20:0] e_addr;
        logic [31:0] e_data;
        logic [7:0]  e_len;
        e_en = 1'b0; e_cmd = 3'b111; e_addr = '0; e_data = '0; e_len = '0;
        if (m_owner == 0) begin
            e_en = m0_if.cmd_en; e_cmd = m0_if.cmd; e_addr = m0_if.addr;
            e_data = m0_if.data; e_len = m0_if.data_len;
        end else if (m_owner == 1) begin
            e_en = m1_if.cmd_en; e_cmd = m1_if.cmd; e_addr = m1_if.addr;
            e_data = m1_if.data; e_len = m1_if.data_len;
        end else if (m_owner == -1 && O_sdrc_init_done && m_pend) begin
            e_en = 1'b1; e_cmd = 3'b001;
        end
        chk("grant0",   m0_if.grant, m_owner == 0);
        chk("grant1",   m1_if.grant, m_owner == 1);
        chk("excl",     m0_if.grant & m1_if.grant, 0);
        chk("cmd_en",   I_sdrc_cmd_en, e_en);
        chk("cmd",      I_sdrc_cmd, e_cmd);
        chk("addr",     I_sdrc_addr, e_addr);
        chk("data",     I_sdrc_data, e_data);
        chk("len",      I_sdrc_data_len, e_len);
        chk("ack0",     m0_if.cmd_ack, O_sdrc_cmd_ack && m_owner == 0);
        chk("ack1",     m1_if.cmd_ack, O_sdrc_cmd_ack && m_owner == 1);
        chk("rdata0",   m0_if.rdata, O_sdrc_data);
        chk("rdata1",   m1_if.rdata, O_sdrc_data);
        chk("overrun",  refresh_overrun, m_ovr);
    endtask

    // mode 0 random, 1 drain only (no new requests), 2 m1 holds, 3 m0 holds, 4 no requests
    task automatic drive_inputs(input int mode);
        O_sdrc_cmd_ack  = 1'($urandom);
        O_sdrc_data     = $urandom;
        m0_if.cmd_en    = 1'($urandom); m0_if.cmd = 3'($urandom);
        m0_if.addr      = 21'($urandom); m0_if.data = $urandom; m0_if.data_len = 8'($urandom);
        m1_if.cmd_en    = 1'($urandom); m1_if.cmd = 3'($urandom);
        m1_if.addr      = 21'($urandom); m1_if.data = $urandom; m1_if.data_len = 8'($urandom);
        for (int n = 0; n < 2; n++) begin
            if (!req[n]) begin
                if (mode == 0 && $urandom_range(3) == 0) begin
                    req[n]  = 1'b1;
                    hold[n] = $urandom_range(25, 1);
                end
            end else if (m_owner == n) begin
                if (hold[n] == 0) req[n] = 1'b0;
                else              hold[n]--;
            end
        end
        if (mode == 2) begin req[0] = 1'b0; req[1] = 1'b1; end
        if (mode == 3) begin req[0] = 1'b1; req[1] = 1'b0; end
        if (mode == 4) begin req[0] = 1'b0; req[1] = 1'b0; end
        m0_if.req = req[0];
        m1_if.req = req[1];
    endtask

    task automatic run_cycles(input int n, input int mode);
        repeat (n) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            check_outputs();
            drive_inputs(mode);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req[0] = 1'b0; req[1] = 1'b0; hold[0] = 0; hold[1] = 0;
        m0_if.req = 1'b0; m1_if.req = 1'b0;
        #1;
        model_reset();
        chk("rst_grant0", m0_if.grant, 0);
        chk("rst_grant1", m1_if.grant, 0);
        chk("rst_cmd_en", I_sdrc_cmd_en, 0);
        chk("rst_cmd",    I_sdrc_cmd, 3'b111);
        chk("rst_addr",   I_sdrc_addr, 0);
        chk("rst_ovr",    refresh_overrun, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int own1_cycles;
        rst_n = 1'b0;
        O_sdrc_init_done = 1'b0;
        O_sdrc_cmd_ack = 1'b0; O_sdrc_data = '0;
        m0_if.cmd_en = 1'b0; m0_if.cmd = 3'b111; m0_if.addr = '0; m0_if.data = '0; m0_if.data_len = '0;
        m1_if.cmd_en = 1'b0; m1_if.cmd = 3'b111; m1_if.addr = '0; m1_if.data = '0; m1_if.data_len = '0;
        do_reset();

        // Requests before controller init must not be granted.
        req[0] = 1'b1; hold[0] = 10; m0_if.req = 1'b1;
        run_cycles(50, 3);
        O_sdrc_init_done = 1'b1;
        run_cycles(3, 3);
        chk("init_grant", m0_if.grant, 1);

        run_cycles(600, 0);

        // Long ownership across two refresh intervals forces an overrun.
        run_cycles(40, 4);
        req[0] = 1'b1; hold[0] = 250; m0_if.req = 1'b1;
        run_cycles(400, 1);
        chk("ovr_sticky", refresh_overrun, 1);

        do_reset();
        run_cycles(250, 4);
        run_cycles(1500, 0);

        // Asynchronous reset while M1 owns the port.
        own1_cycles = 0;
        for (int i = 0; i < 300 && own1_cycles < 5; i++) begin
            run_cycles(1, 2);
            if (m_owner == 1) own1_cycles++;
        end
        chk("own1_reached", own1_cycles >= 5, 1);
        m1_if.cmd_en = 1'b1; m1_if.cmd = 3'b100;
        #2;
        chk("pre_rst_en", I_sdrc_cmd_en, m_owner == 1);
        rst_n = 1'b0;
        #1;
        chk("arst_grant1", m1_if.grant, 0);
        chk("arst_cmd_en", I_sdrc_cmd_en, 0);
        chk("arst_cmd",    I_sdrc_cmd, 3'b111);
        req[0] = 1'b0; req[1] = 1'b0; m0_if.req = 1'b0; m1_if.req = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run_cycles(400, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
